// File: rtl/vga_out_pipe.sv
// vga_out_pipe: VGA pixel output stage. Gates colour to the active window,
// applies pass/bars/fill/blank modes latched at frame start, and delays
// colour, HS, VS and the frame-start pulse by PIPE_DEPTH clocks.
// Ports: VGA_CLK, RESET (async, active-low), SYNC_COLOR, Current_X/Y,
//        iHS/iVS, iVGA_R/G/B, iMODE, iFILL -> oVGA_R/G/B, oHS, oVS,
//        oFRAME_START, oFRAME_CNT.
// Optional: define VGA_OUT_PIPE_CROSSHAIR_EN to add iCH_X/iCH_Y/iCH_ON
//           and a full-scale crosshair overlay.
module vga_out_pipe #(
    parameter int COLOR_W       = 4,
    parameter int COORD_W       = 11,
    parameter int X_MIN         = 1,
    parameter int Y_MIN         = 1,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int PIPE_DEPTH    = 2,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int FCNT_W        = 8
) (
    input  logic                   VGA_CLK,
    input  logic                   RESET,
    input  logic                   SYNC_COLOR,
    input  logic [COORD_W-1:0]     Current_X,
    input  logic [COORD_W-1:0]     Current_Y,
    input  logic                   iHS,
    input  logic                   iVS,
    input  logic [COLOR_W-1:0]     iVGA_R,
    input  logic [COLOR_W-1:0]     iVGA_G,
    input  logic [COLOR_W-1:0]     iVGA_B,
    input  logic [1:0]             iMODE,
    input  logic [3*COLOR_W-1:0]   iFILL,
`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
    input  logic [COORD_W-1:0]     iCH_X,
    input  logic [COORD_W-1:0]     iCH_Y,
    input  logic                   iCH_ON,
`endif
    output logic [COLOR_W-1:0]     oVGA_R,
    output logic [COLOR_W-1:0]     oVGA_G,
    output logic [COLOR_W-1:0]     oVGA_B,
    output logic                   oHS,
    output logic                   oVS,
    output logic                   oFRAME_START,
    output logic [FCNT_W-1:0]      oFRAME_CNT
);

    localparam int CW1 = COORD_W + 1;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic SYNC_IDLE = (VS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CW1-1:0] X_LO = CW1'(X_MIN);
    localparam logic [CW1-1:0] X_HI = CW1'(X_MIN + H_ACTIVE);
    localparam logic [CW1-1:0] Y_LO = CW1'(Y_MIN);
    localparam logic [CW1-1:0] Y_HI = CW1'(Y_MIN + V_ACTIVE);
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
        logic               hs;
        logic               vs;
        logic               fs;
    } stage_t;

    localparam stage_t STAGE_RST = '{
        r: '0, g: '0, b: '0, hs: SYNC_IDLE, vs: SYNC_IDLE, fs: 1'b0
    };

    logic                 vs_prev_q, vs_prev_d;
    logic [1:0]           mode_q, mode_d;
    logic [3*COLOR_W-1:0] fill_q, fill_d;
    logic [COORD_W-1:0]   col_q, col_d;
    logic [2:0]           bar_q, bar_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    stage_t               pipe_q [PIPE_DEPTH];
    stage_t               pipe_d [PIPE_DEPTH];

`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
    logic [COORD_W-1:0]   ch_x_q, ch_x_d;
    logic [COORD_W-1:0]   ch_y_q, ch_y_d;
    logic                 ch_on_q, ch_on_d;
`endif

    logic                 vs_on;
    logic                 frame_start;
    logic [1:0]           eff_mode;
    logic [3*COLOR_W-1:0] eff_fill;
    logic [CW1-1:0]       x_ext, y_ext;
    logic                 visible;
    logic                 at_xmin;
    logic [2:0]           cur_bar;
    logic [COORD_W-1:0]   cur_col;
    logic [2:0]           bar_rgb;
    logic [COLOR_W-1:0]   pix_r, pix_g, pix_b;
    stage_t               st0;

    always_comb begin
        vs_on       = (iVS != SYNC_IDLE);
        frame_start = vs_on && !vs_prev_q;
        vs_prev_d   = vs_on;

        // A frame-start pixel already uses the newly selected mode.
        eff_mode = frame_start ? iMODE : mode_q;
        eff_fill = frame_start ? iFILL : fill_q;
        mode_d   = eff_mode;
        fill_d   = eff_fill;

        x_ext   = {1'b0, Current_X};
        y_ext   = {1'b0, Current_Y};
        visible = SYNC_COLOR
                  && (x_ext >= X_LO) && (x_ext < X_HI)
                  && (y_ext >= Y_LO) && (y_ext < Y_HI);

        // Bar position restarts on the first column of every line.
        at_xmin = (x_ext == X_LO);
        cur_bar = at_xmin ? 3'd0 : bar_q;
        cur_col = at_xmin ? '0 : col_q;
        col_d   = cur_col;
        bar_d   = cur_bar;
        if (visible) begin
            if (cur_col == BAR_LAST) begin
                col_d = '0;
                if (cur_bar != 3'd7) begin
                    bar_d = cur_bar + 3'd1;
                end
            end else begin
                col_d = cur_col + COORD_W'(1);
            end
        end
        // Bar i lights the channels set in (7 - i), i.e. ~i.
        bar_rgb = ~cur_bar;

        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        unique case (eff_mode)
            2'b00: begin
                pix_r = iVGA_R;
                pix_g = iVGA_G;
                pix_b = iVGA_B;
            end
            2'b01: begin
                pix_r = {COLOR_W{bar_rgb[2]}};
                pix_g = {COLOR_W{bar_rgb[1]}};
                pix_b = {COLOR_W{bar_rgb[0]}};
            end
            2'b10: begin
                pix_r = eff_fill[3*COLOR_W-1:2*COLOR_W];
                pix_g = eff_fill[2*COLOR_W-1:COLOR_W];
                pix_b = eff_fill[COLOR_W-1:0];
            end
            2'b11: begin
                pix_r = '0;
                pix_g = '0;
                pix_b = '0;
            end
        endcase

`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
        ch_x_d  = frame_start ? iCH_X  : ch_x_q;
        ch_y_d  = frame_start ? iCH_Y  : ch_y_q;
        ch_on_d = frame_start ? iCH_ON : ch_on_q;
        if (ch_on_d && (eff_mode != 2'b11)
            && ((Current_X == ch_x_d) || (Current_Y == ch_y_d))) begin
            pix_r = '1;
            pix_g = '1;
            pix_b = '1;
        end
`endif

        st0    = STAGE_RST;
        st0.r  = visible ? pix_r : '0;
        st0.g  = visible ? pix_g : '0;
        st0.b  = visible ? pix_b : '0;
        st0.hs = iHS;
        st0.vs = iVS;
        st0.fs = frame_start;

        pipe_d[0] = st0;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // Count the frame on the edge its pulse reaches the output.
        fcnt_d = fcnt_q
                 + {{(FCNT_W-1){1'b0}}, pipe_d[PIPE_DEPTH-1].fs};
    end

    always_ff @(posedge VGA_CLK or negedge RESET) begin
        if (!RESET) begin
            vs_prev_q <= 1'b0;
            mode_q    <= 2'b00;
            fill_q    <= '0;
            col_q     <= '0;
            bar_q     <= 3'd0;
            fcnt_q    <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= STAGE_RST;
            end
`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
            ch_x_q    <= '0;
            ch_y_q    <= '0;
            ch_on_q   <= 1'b0;
`endif
        end else begin
            vs_prev_q <= vs_prev_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            col_q     <= col_d;
            bar_q     <= bar_d;
            fcnt_q    <= fcnt_d;
            pipe_q    <= pipe_d;
`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
            ch_x_q    <= ch_x_d;
            ch_y_q    <= ch_y_d;
            ch_on_q   <= ch_on_d;
`endif
        end
    end

    assign oVGA_R       = pipe_q[PIPE_DEPTH-1].r;
    assign oVGA_G       = pipe_q[PIPE_DEPTH-1].g;
    assign oVGA_B       = pipe_q[PIPE_DEPTH-1].b;
    assign oHS          = pipe_q[PIPE_DEPTH-1].hs;
    assign oVS          = pipe_q[PIPE_DEPTH-1].vs;
    assign oFRAME_START = pipe_q[PIPE_DEPTH-1].fs;
    assign oFRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_vga_out_pipe.sv
// tb_vga_out_pipe: self-checking bench for vga_out_pipe (default params).
// Window-level reference model plus directed literal checks.
module tb_vga_out_pipe;

    localparam int PD = 2;

    logic        clk;
    logic        rst_n;
    logic        sync;
    logic [10:0] cx, cy;
    logic        ihs, ivs;
    logic [3:0]  ir, ig, ib;
    logic [1:0]  imode;
    logic [11:0] ifill;
    logic [3:0]  o_r, o_g, o_b;
    logic        ohs, ovs, ofs;
    logic [7:0]  ocnt;
`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
    logic [10:0] ch_x, ch_y;
    logic        ch_on;
`endif

    vga_out_pipe dut (
        .VGA_CLK      (clk),
        .RESET        (rst_n),
        .SYNC_COLOR   (sync),
        .Current_X    (cx),
        .Current_Y    (cy),
        .iHS          (ihs),
        .iVS          (ivs),
        .iVGA_R       (ir),
        .iVGA_G       (ig),
        .iVGA_B       (ib),
        .iMODE        (imode),
        .iFILL        (ifill),
`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
        .iCH_X        (ch_x),
        .iCH_Y        (ch_y),
        .iCH_ON       (ch_on),
`endif
        .oVGA_R       (o_r),
        .oVGA_G       (o_g),
        .oVGA_B       (o_b),
        .oHS          (ohs),
        .oVS          (ovs),
        .oFRAME_START (ofs),
        .oFRAME_CNT   (ocnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    localparam exp_t E_RST = '{r: 4'h0, g: 4'h0, b: 4'h0,
                               hs: 1'b1, vs: 1'b1, fs: 1'b0};

    exp_t       q[$];
    logic       m_vsp;
    logic [1:0] m_mode;
    logic [11:0] m_fill;
    logic [7:0] m_cnt;
    int         fs_seen;

    exp_t       me;
    logic       m_on, m_fs, m_vis;
    int         m_x, m_y, m_bar;
    logic [2:0] m_c;

    // Reference: what each sampled input must become at the output.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_vsp  = 1'b0;
            m_mode = 2'b00;
            m_fill = 12'h000;
        end else begin
            m_on  = (ivs == 1'b0);
            m_fs  = m_on && !m_vsp;
            m_vsp = m_on;
            if (m_fs) begin
                m_mode = imode;
                m_fill = ifill;
            end
            m_x   = int'(cx);
            m_y   = int'(cy);
            m_vis = sync && m_x >= 1 && m_x <= 640
                    && m_y >= 1 && m_y <= 480;
            me = E_RST;
            if (m_vis) begin
                case (m_mode)
                    2'b00: begin
                        me.r = ir; me.g = ig; me.b = ib;
                    end
                    2'b01: begin
                        m_bar = (m_x - 1) / 80;
                        if (m_bar > 7) m_bar = 7;
                        m_c  = 3'(7 - m_bar);
                        me.r = m_c[2] ? 4'hF : 4'h0;
                        me.g = m_c[1] ? 4'hF : 4'h0;
                        me.b = m_c[0] ? 4'hF : 4'h0;
                    end
                    2'b10: begin
                        me.r = m_fill[11:8];
                        me.g = m_fill[7:4];
                        me.b = m_fill[3:0];
                    end
                    default: ;
                endcase
            end
            me.hs = ihs;
            me.vs = ivs;
            me.fs = m_fs;
            q.push_back(me);
            if (q.size() > PD) void'(q.pop_front());
        end
    end

    exp_t ce;
    exp_t ca;

    always @(negedge clk) begin
        if (!rst_n) begin
            ce      = E_RST;
            m_cnt   = 8'd0;
            fs_seen = 0;
        end else begin
            if (q.size() == PD) begin
                ce = q[0];
                if (ce.fs) m_cnt = m_cnt + 8'd1;
            end else begin
                ce = E_RST;
            end
            if (ofs) fs_seen++;
        end
        ca = '{r: o_r, g: o_g, b: o_b, hs: ohs, vs: ovs, fs: ofs};
        checks++;
        if (ca !== ce || ocnt !== m_cnt) begin
            failures++;
            $display("FAIL cycle t=%0t actual=%h/%h required=%h/%h",
                     $time, ca, ocnt, ce, m_cnt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic s, input int x, input int y,
                         input logic hs, input logic vs);
        sync = s;
        cx   = 11'(x);
        cy   = 11'(y);
        ihs  = hs;
        ivs  = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic vsync();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 1);
    endtask

    function automatic logic [11:0] rgb();
        return {o_r, o_g, o_b};
    endfunction

    int bx[6] = '{1, 80, 81, 560, 561, 640};
    logic [11:0] bc[6] = '{12'hFFF, 12'hFFF, 12'hFF0,
                           12'h00F, 12'h000, 12'h000};

    initial begin
        clk = 0; rst_n = 0; sync = 0; cx = 0; cy = 0;
        ihs = 1; ivs = 1; ir = 0; ig = 0; ib = 0;
        imode = 2'b00; ifill = 12'h000;
`ifdef VGA_OUT_PIPE_CROSSHAIR_EN
        ch_x = 0; ch_y = 0; ch_on = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {rgb(), ohs, ovs, ofs, ocnt},
            {12'h000, 3'b110, 8'h00});
        rst_n = 1;
        repeat (2) drive(0, 0, 0, 1, 1);

        // Pass-through line with window boundaries.
        ir = 4'hA; ig = 4'h5; ib = 4'h3;
        for (int x = 0; x <= 642; x++) begin
            drive(x <= 641, x, 1, 1, 1);
            if (x == 1)   chk("pass_x0", rgb(), 12'h000);
            if (x == 2)   chk("pass_x1", rgb(), 12'hA53);
            if (x == 642) chk("pass_x641", rgb(), 12'h000);
        end
        drive(1, 5, 480, 1, 1);
        drive(1, 5, 481, 1, 1);
        chk("pass_y480", rgb(), 12'hA53);
        drive(1, 5, 0, 1, 1);
        chk("pass_y481", rgb(), 12'h000);
        drive(0, 5, 5, 1, 1);
        chk("pass_y0", rgb(), 12'h000);

        // Frame start on a visible pixel uses the new mode at once.
        imode = 2'b10; ifill = 12'h123;
        drive(1, 5, 5, 1, 0);
        drive(1, 6, 5, 1, 0);
        chk("fs_same_pixel", rgb(), 12'h123);
        chk("fs_pulse_vs", {ofs, ovs}, 2'b10);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);

        // Asynchronous reset mid-line.
        imode = 2'b00;
        vsync();
        ir = 4'hF; ig = 4'hF; ib = 4'hF;
        repeat (3) drive(1, 10, 10, 1, 1);
        chk("pre_reset", rgb(), 12'hFFF);
        rst_n = 0;
        #1;
        chk("reset_mid", {rgb(), ohs, ovs, ofs, ocnt},
            {12'h000, 3'b110, 8'h00});
        imode = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        drive(1, 11, 10, 1, 1);
        drive(1, 12, 10, 1, 1);
        chk("mode_after_reset", rgb(), 12'hFFF);
        imode = 2'b00;

        // Frame counter wrap.
        repeat (255) vsync();
        chk("fcnt_255", ocnt, 8'd255);
        vsync();
        chk("fcnt_wrap", ocnt, 8'd0);
        chk("fs_pulses", fs_seen, 256);

        // Colour bars over one full line.
        imode = 2'b01;
        vsync();
        for (int x = 0; x <= 642; x++) begin
            drive(x <= 641, x, 10, 1, 1);
            for (int j = 0; j < 6; j++) begin
                if (x == bx[j] + 1) chk($sformatf("bar_x%0d", bx[j]),
                                         rgb(), bc[j]);
            end
        end

        // Mode change mid-frame waits for the next frame start.
        imode = 2'b00; ir = 4'h7; ig = 4'h8; ib = 4'h9;
        vsync();
        for (int x = 1; x <= 4; x++) drive(1, x, 199, 1, 1);
        imode = 2'b11;
        drive(1, 1, 200, 1, 1);
        drive(1, 2, 200, 1, 1);
        chk("mode_hold", rgb(), 12'h789);
        drive(1, 3, 200, 1, 1);
        vsync();
        drive(1, 1, 1, 1, 1);
        drive(1, 2, 1, 1, 1);
        chk("mode_blank", rgb(), 12'h000);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 1, 1);
        chk("blank_hs", ohs, 1'b0);
        repeat (3) drive(0, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/vga_out_pipe.md
Name: vga_out_pipe

Overview:
- Parametrised VGA pixel output stage. Sits between the pixel source / timing generator and the DAC pins.
- Gates colour to a programmable active window and delays HS/VS by the same pipeline depth as colour.
- Supports runtime-selectable pass-through, colour-bar test pattern, solid fill and forced-blank modes.
- Mode changes are applied only on frame boundaries, so no frame is torn.

Parameters:
- COLOR_W, 4, bits per colour channel
- COORD_W, 11, width of X/Y coordinate inputs
- X_MIN, 1, first visible column (inclusive)
- Y_MIN, 1, first visible row (inclusive)
- H_ACTIVE, 640, visible columns; must be a multiple of 8
- V_ACTIVE, 480, visible rows
- PIPE_DEPTH, 2, output latency in VGA_CLK cycles; valid range 1..8
- VS_ACTIVE_LOW, 1, 1 means iVS is asserted when 0
- FCNT_W, 8, frame counter width

Ports:
- VGA_CLK  in  1  pixel clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- SYNC_COLOR  in  1  pixel-valid from timing generator
- Current_X  in  COORD_W  current column
- Current_Y  in  COORD_W  current row
- iHS  in  1  horizontal sync, raw
- iVS  in  1  vertical sync, raw
- iVGA_R/iVGA_G/iVGA_B  in  COLOR_W each  source colour
- iMODE  in  2  00 pass, 01 colour bars, 10 solid iFILL, 11 blank
- iFILL  in  3*COLOR_W  solid colour {R,G,B}
- oVGA_R/oVGA_G/oVGA_B  out  COLOR_W each  colour to DAC
- oHS  out  1  iHS delayed by PIPE_DEPTH
- oVS  out  1  iVS delayed by PIPE_DEPTH
- oFRAME_START  out  1  one-cycle pulse, aligned with oVS assertion
- oFRAME_CNT  out  FCNT_W  completed-frame counter

Behaviour:
- Reset (RESET=0, asynchronous) clears:
  - all colour outputs, oFRAME_START and oFRAME_CNT to 0;
  - every pipeline stage to 0, except HS/VS stages, which reset to the deasserted level (1 if VS_ACTIVE_LOW, else 0);
  - the active mode register to 00.
- Visible condition, evaluated in stage 0: SYNC_COLOR=1 and X_MIN<=X<X_MIN+H_ACTIVE and Y_MIN<=Y<Y_MIN+V_ACTIVE.
  - Compare at COORD_W+1 bits so the sum cannot overflow.
- Not visible means output colour 0 in every mode.
- Frame start is the cycle where iVS goes from deasserted to asserted (registered edge detect on stage 0).
  - On that cycle, iMODE and iFILL are latched into the active mode/fill registers.
  - oFRAME_CNT increments when the event reaches the output; it wraps from all-ones to 0.
  - iMODE changes mid-frame have no effect until the next frame start.
- Colour-bar generator:
  - Column counter clears at X==X_MIN; bar index 0..7 increments every H_ACTIVE/8 visible columns and saturates at 7.
  - Bar i colour: channel full-scale (all ones) where bit of (7-i) is set; R=bit2, G=bit1, B=bit0.
  - Resulting sequence: white, yellow, magenta, red, cyan, green, blue, black.
- Mode 10 outputs the latched iFILL; mode 11 outputs 0 everywhere, but sync still passes.
- Latency:
  - Colour, oHS, oVS and oFRAME_START all appear exactly PIPE_DEPTH cycles after their inputs.
  - No path is combinational from input to output.
- Simultaneous frame start and visible pixel: the new mode applies to that same pixel.
- Reset mid-frame: outputs go to 0 immediately. After release, the mode stays 00 until the next frame start.

Optional Feature:
- Macro: VGA_OUT_PIPE_CROSSHAIR_EN.
- Defined:
  - Adds inputs iCH_X and iCH_Y (COORD_W each) and iCH_ON (1).
  - When iCH_ON=1 and a visible pixel has X==iCH_X or Y==iCH_Y, output is all-ones on all channels, overriding modes 00/01/10 but not 11.
  - Crosshair coordinates are latched at frame start, like the mode.
- Undefined: those ports and the override logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-line with colour 0xF on all inputs -> all colour outputs 0 the same cycle; oHS/oVS deasserted; oFRAME_CNT=0.
- Mode 00, PIPE_DEPTH=2, X=1,Y=1, iVGA=0xA/0x5/0x3 -> oVGA=0xA/0x5/0x3 exactly 2 cycles later; X=0 or X=641 -> 0.
- Mode 01, H_ACTIVE=640 -> X=1..80 white 0xF/0xF/0xF; X=81 yellow 0xF/0xF/0x0; X=561..640 black.
- iMODE switched 00->11 at Y=200 -> output unchanged until next iVS assertion, then all pixels 0; oFRAME_START pulses once per frame.
- 256 frames with FCNT_W=8 -> oFRAME_CNT wraps 255->0; iHS/iVS toggles are reproduced on oHS/oVS with exact PIPE_DEPTH delay.
- With VGA_OUT_PIPE_CROSSHAIR_EN, iCH_X=100, iCH_Y=50, mode 10 fill 0x1/0x2/0x3 -> column 100 and row 50 are 0xF, all other visible pixels are the fill colour.
